// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   - Default reset / exception addresses.
//   - Fetch-sequencer FSM state type.
//   - Instruction width and word-increment constants.
//   - Helper that word-aligns an incoming address.
package cpu_pkg;

  localparam int unsigned InstrWidth = 32;

  localparam logic [InstrWidth-1:0] WordIncr         = 32'd4;
  localparam logic [InstrWidth-1:0] RESET_PC_DFLT    = 32'h0000_0000;
  localparam logic [InstrWidth-1:0] EXC_VECTOR_DFLT  = 32'h0000_0180;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } pc_state_e;

  // Clear the byte-offset bits so every issued fetch address is word-aligned.
  function automatic logic [InstrWidth-1:0] align_word(input logic [InstrWidth-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Combinational 32-bit sequential-PC incrementer (adds one word, wraps mod 2^32).
// Ports:
//   addr_i  current fetch address
//   addr_o  addr_i + 4
module pc_incr
  import cpu_pkg::*;
(
  input  logic [InstrWidth-1:0] addr_i,
  output logic [InstrWidth-1:0] addr_o
);

  assign addr_o = addr_i + WordIncr;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the instruction-fetch stage.
// Issues fetch addresses over a valid/ready handshake and picks the next PC from
// sequential +4, delayed-branch redirect, exception vector or ERET return.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_addr/pc_valid    fetch request to instruction memory
//   pc_ready            memory accepts pc_addr this cycle
//   pc_flush            one-cycle pulse: drop any in-flight fetch
//   stall               IF/ID cannot take new instructions
//   redir/redir_target  taken branch / jump from ID
//   exc                 exception taken
//   eret/epc            return from exception and its address
//   redir_pending       a redirect is buffered behind an outstanding fetch
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [InstrWidth-1:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [InstrWidth-1:0] EXC_VECTOR = EXC_VECTOR_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [InstrWidth-1:0] pc_addr,
  output logic                  pc_valid,
  input  logic                  pc_ready,
  output logic                  pc_flush,
  input  logic                  stall,
  input  logic                  redir,
  input  logic [InstrWidth-1:0] redir_target,
  input  logic                  exc,
  input  logic                  eret,
  input  logic [InstrWidth-1:0] epc,
  output logic                  redir_pending
);

  pc_state_e             state_q, state_d;
  logic [InstrWidth-1:0] pc_q, pc_d;
  logic [InstrWidth-1:0] tgt_q, tgt_d;
  logic                  pend_q, pend_d;
  logic                  flush_q, flush_d;
  logic [InstrWidth-1:0] pc_seq;
  logic                  handshake;

  pc_incr u_pc_incr (
    .addr_i (pc_q),
    .addr_o (pc_seq)
  );

  // pc_valid is a pure decode of the state register.
  assign handshake = (state_q == S_RUN) && pc_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    flush_d = 1'b0;

    if (exc || eret) begin
      // Abandons any outstanding fetch, so the handshake hold rule does not apply.
      pc_d    = exc ? EXC_VECTOR : align_word(epc);
      flush_d = 1'b1;
      pend_d  = 1'b0;
      state_d = stall ? S_STALL : S_RUN;
    end else begin
      unique case (state_q)
        S_RESET: begin
          state_d = S_RUN;
          if (redir) pc_d = align_word(redir_target);
        end
        S_RUN: begin
          if (handshake) begin
            // The accepted fetch was the delay slot; a redirect now takes effect.
            if (redir)       pc_d = align_word(redir_target);
            else if (pend_q) pc_d = tgt_q;
            else             pc_d = pc_seq;
            pend_d  = 1'b0;
            state_d = stall ? S_STALL : S_RUN;
          end else if (redir) begin
            // Address must hold until accepted; park the target (newest wins).
            tgt_d  = align_word(redir_target);
            pend_d = 1'b1;
          end
        end
        S_STALL: begin
          // Nothing outstanding, so a redirect can replace the PC directly.
          if (redir)  pc_d = align_word(redir_target);
          if (!stall) state_d = S_RUN;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

  assign pc_addr       = pc_q;
  assign pc_valid      = (state_q == S_RUN);
  assign pc_flush      = flush_q;
  assign redir_pending = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        pc_flush;
  logic        stall;
  logic        redir;
  logic [31:0] redir_target;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        redir_pending;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .pc_flush      (pc_flush),
    .stall         (stall),
    .redir         (redir),
    .redir_target  (redir_target),
    .exc           (exc),
    .eret          (eret),
    .epc           (epc),
    .redir_pending (redir_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs at once.
  task automatic chk_all(input string tag, input logic [31:0] addr, input logic vld,
                         input logic fl, input logic pend);
    chk({tag, ".pc_addr"}, pc_addr, addr);
    chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, vld});
    chk({tag, ".pc_flush"}, {31'd0, pc_flush}, {31'd0, fl});
    chk({tag, ".redir_pending"}, {31'd0, redir_pending}, {31'd0, pend});
  endtask

  initial begin
    rst = 1'b1; pc_ready = 1'b0; stall = 1'b0; redir = 1'b0; redir_target = '0;
    exc = 1'b0; eret = 1'b0; epc = '0;
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);

    // Free run
    rst = 1'b0; pc_ready = 1'b1;
    tick();
    chk_all("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk("run4", pc_addr, 32'h4);
    tick(); chk("run8", pc_addr, 32'h8);
    tick(); chk("runC", pc_addr, 32'hC);
    tick(); chk("run10", pc_addr, 32'h10);

    // Back-pressure redirect
    pc_ready = 1'b0; redir = 1'b1; redir_target = 32'h200;
    tick(); chk_all("bp_latch", 32'h10, 1'b1, 1'b0, 1'b1);
    redir = 1'b0;
    tick(); chk_all("bp_hold", 32'h10, 1'b1, 1'b0, 1'b1);
    pc_ready = 1'b1;
    tick(); chk_all("bp_take", 32'h200, 1'b1, 1'b0, 1'b0);

    // Same-cycle redirect
    redir = 1'b1; redir_target = 32'h20;
    tick(); chk("sc_to20", pc_addr, 32'h20);
    redir_target = 32'h400;
    tick(); chk("sc_to400", pc_addr, 32'h400);
    redir = 1'b0;
    tick(); chk("sc_seq404", pc_addr, 32'h404);

    // Stall
    redir = 1'b1; redir_target = 32'h30;
    tick(); chk("st_to30", pc_addr, 32'h30);
    redir = 1'b0; stall = 1'b1;
    tick(); chk_all("st_enter", 32'h34, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("st_hold", 32'h34, 1'b0, 1'b0, 1'b0);
    redir = 1'b1; redir_target = 32'h80;
    tick(); chk_all("st_redir", 32'h80, 1'b0, 1'b0, 1'b0);
    redir = 1'b0; stall = 1'b0;
    tick(); chk_all("st_exit", 32'h80, 1'b1, 1'b0, 1'b0);

    // exc with a pending redirect
    pc_ready = 1'b0; redir = 1'b1; redir_target = 32'h300;
    tick(); chk_all("exc_pre", 32'h80, 1'b1, 1'b0, 1'b1);
    redir = 1'b0; exc = 1'b1;
    tick(); chk_all("exc", 32'h180, 1'b1, 1'b1, 1'b0);
    exc = 1'b0;
    tick(); chk_all("exc_after", 32'h180, 1'b1, 1'b0, 1'b0);

    // eret with unaligned epc
    eret = 1'b1; epc = 32'h1003;
    tick(); chk_all("eret", 32'h1000, 1'b1, 1'b1, 1'b0);
    eret = 1'b0;
    tick(); chk_all("eret_after", 32'h1000, 1'b1, 1'b0, 1'b0);

    // exc beats eret; stall selects S_STALL
    exc = 1'b1; eret = 1'b1; epc = 32'h2000; stall = 1'b1;
    tick(); chk_all("exc_eret", 32'h180, 1'b0, 1'b1, 1'b0);
    exc = 1'b0; eret = 1'b0; stall = 1'b0;
    tick(); chk_all("exc_eret_after", 32'h180, 1'b1, 1'b0, 1'b0);

    // Wrap
    pc_ready = 1'b1; redir = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_top", pc_addr, 32'hFFFF_FFFC);
    redir = 1'b0;
    tick(); chk("wrap_zero", pc_addr, 32'h0);
    tick(); chk("wrap_four", pc_addr, 32'h4);

    // Reset mid-stall
    stall = 1'b1;
    tick(); chk_all("rs_stall", 32'h8, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); chk_all("rs_reset", 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset with a redirect pending
    rst = 1'b0; stall = 1'b0; pc_ready = 1'b0;
    tick(); chk_all("rs2_run", 32'h0, 1'b1, 1'b0, 1'b0);
    redir = 1'b1; redir_target = 32'h500;
    tick(); chk_all("rs2_pend", 32'h0, 1'b1, 1'b0, 1'b1);
    redir = 1'b0; rst = 1'b1;
    tick(); chk_all("rs2_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; pc_ready = 1'b1;
    tick(); chk_all("rs2_restart", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk("rs2_seq", pc_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
